input_flow_control: RTL and testbench
=====================================

INPUT_FLOW_CONTROL -- requirements
Module: input_flow_control

Interface
REQ-001 Parameter FLIT_W, default 32, flit width in bits.
REQ-002 Parameter DEPTH, default 4, input buffer depth in flits; power of two, minimum 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 val  input  1  upstream request to send; 1 means a flit is present on data_in.
REQ-006 data_in  input  FLIT_W  flit from the upstream router.
REQ-007 ret  output  1  back-pressure to upstream; 1 means the buffer cannot take more flits.
REQ-008 req  output  1  a flit is available at data_out for the local routing/crossbar.
REQ-009 data_out  output  FLIT_W  head flit of the buffer; valid only while req=1.
REQ-010 ack  input  1  local consumer pops the head flit this cycle; ignored while req=0.
REQ-011 ovf  output  1  sticky overflow flag.

Function
REQ-012 The block SHALL store flits in a circular FIFO of DEPTH entries, with separate write and read pointers and an occupancy counter of width clog2(DEPTH)+1.
REQ-013 Push: a flit is written when val=1 and count<DEPTH at the clock edge.
REQ-014 Pop: the head is popped when ack=1 and req=1.
REQ-015 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-016 Push and pop in the same cycle with 0<count<DEPTH: count is unchanged and both pointers advance.
REQ-017 Push while empty: req=1 and data_out is the new flit on the next cycle; fall-through latency is 1 cycle.
REQ-018 data_out SHALL be read combinationally from the read pointer.
REQ-019 val=1 while count==DEPTH: the flit is discarded, this holds even if ack=1 in that cycle, and ovf is set to 1.
REQ-020 ovf SHALL stay 1 until reset.
REQ-021 ack=1 while empty SHALL change no state.
REQ-022 ret SHALL be a register loaded each cycle from the next-state count: 1 iff next_count reaches the threshold in REQ-028/029.
REQ-023 ret SHALL never be driven combinationally from val.
REQ-024 req SHALL equal (count!=0), driven from state.

Reset
REQ-025 With rst_n=0, the block SHALL immediately (asynchronously) clear pointers, count and ovf, and force ret=0 and req=0.
REQ-026 Buffer contents are not reset; data_out is don't-care while req=0.
REQ-027 A reset asserted mid-transfer SHALL drop all stored and in-flight flits without setting ovf.

Configuration
REQ-028 Macro IFC_EARLY_RET_EN defined: threshold is DEPTH-1, so ret rises one flit early to absorb one in-flight flit sent during the ret round-trip.
REQ-029 Macro IFC_EARLY_RET_EN undefined: threshold is DEPTH, so ret is 1 exactly when full.

Structure
REQ-030 The shared package noc_pkg SHALL hold FLIT_W and DEPTH defaults and the flit typedef flit_t, shared with output_flow_control.
REQ-031 Storage plus pointers SHALL be one sub-module, ifc_fifo_mem (write port, async read port); flow/threshold logic stays in the top level.

Verification
REQ-032 Reset, then 1 flit: val=1, data_in=0xA5A5A5A5 for 1 cycle -> next cycle req=1, data_out=0xA5A5A5A5; ack=1 -> req=0.
REQ-033 Fill, DEPTH=4, macro undefined: 4 pushes with no ack -> ret=1 after the 4th edge; 5th val -> ovf=1 and count stays 4.
REQ-034 Same as REQ-033 with IFC_EARLY_RET_EN: ret=1 after the 3rd push; a 4th push is accepted with ovf=0.
REQ-035 Concurrent traffic: continuous val and ack for 20 cycles with values 1..20 -> output order 1..20, count constant, ret never 1.
REQ-036 Wrap-around: 6 push/pop pairs staggered by 1 cycle on DEPTH=4 -> order preserved across pointer wrap.
REQ-037 Reset mid-operation: rst_n=0 with count=3 -> req=0, ret=0, ovf=0 immediately; after release, first push reappears as the head.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: default flit width, input buffer depth and flit type,
// common to input_flow_control and output_flow_control.
package noc_pkg;

  localparam int unsigned FLIT_W = 32;
  localparam int unsigned DEPTH  = 4;

  typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/ifc_fifo_mem.sv
// Circular flit storage with write/read pointers: synchronous write port,
// combinational read of the entry at the read pointer.
module ifc_fifo_mem
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_W = noc_pkg::FLIT_W,
  parameter int unsigned DEPTH  = noc_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [FLIT_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [FLIT_W-1:0] rd_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Storage is intentionally not reset; only the pointers are.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/input_flow_control.sv
// Router input port buffer with registered back-pressure and sticky overflow.
// Define IFC_EARLY_RET_EN to raise ret one flit before the buffer is full.
module input_flow_control
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_W = noc_pkg::FLIT_W,
  parameter int unsigned DEPTH  = noc_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              val,
  input  logic [FLIT_W-1:0] data_in,
  output logic              ret,
  output logic              req,
  output logic [FLIT_W-1:0] data_out,
  input  logic              ack,
  output logic              ovf
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
`ifdef IFC_EARLY_RET_EN
  localparam logic [CW-1:0] RET_TH = CW'(DEPTH - 1);
`else
  localparam logic [CW-1:0] RET_TH = CW'(DEPTH);
`endif

  logic [CW-1:0] count;
  logic [CW-1:0] next_count;
  logic          push;
  logic          pop;

  assign req = (count != '0);

  // A push at full is refused even if a pop frees a slot in the same cycle.
  always_comb begin
    push       = val && (count != FULL);
    pop        = ack && req;
    next_count = count;
    if (push && !pop)      next_count = count + 1'b1;
    else if (pop && !push) next_count = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ret   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= next_count;
      ret   <= (next_count >= RET_TH);
      if (val && (count == FULL)) ovf <= 1'b1;
    end
  end

  ifc_fifo_mem #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (data_in),
    .rd_en   (pop),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_input_flow_control.sv
// Scoreboard bench for input_flow_control (DEPTH=4): stimulus queues expected
// head flits, a negedge monitor checks every popped head against the queue.
module tb_input_flow_control;

  localparam int unsigned W = 32;
  localparam int unsigned D = 4;
`ifdef IFC_EARLY_RET_EN
  localparam logic EARLY = 1'b1;
`else
  localparam logic EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         val;
  logic [W-1:0] data_in;
  logic         ret;
  logic         req;
  logic [W-1:0] data_out;
  logic         ack;
  logic         ovf;

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  input_flow_control #(.FLIT_W(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .val      (val),
    .data_in  (data_in),
    .ret      (ret),
    .req      (req),
    .data_out (data_out),
    .ack      (ack),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a pop happens on the next rising edge whenever req && ack.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && req === 1'b1 && ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_pop: got %h expected no flit at %0t", data_out, $time);
      end else begin
        chk("head_flit", data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; val = 1'b0; ack = 1'b0; data_in = '0;
    step(); step();
    chk("reset_req", W'(req), 0);
    chk("reset_ret", W'(ret), 0);
    chk("reset_ovf", W'(ovf), 0);
    rst_n = 1'b1;
    step();

    // Single flit fall-through
    val = 1'b1; data_in = 32'hA5A5A5A5; exp_q.push_back(32'hA5A5A5A5);
    step();
    val = 1'b0;
    chk("single_req", W'(req), 1);
    chk("single_data", data_out, 32'hA5A5A5A5);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("single_req_after_ack", W'(req), 0);

    // Fill to DEPTH without ack
    for (int i = 0; i < 4; i++) begin
      val = 1'b1; data_in = 32'h10 + W'(i); exp_q.push_back(32'h10 + W'(i));
      step();
      if (i == 2) chk("ret_after_3", W'(ret), W'(EARLY));
      if (i == 3) begin
        chk("ret_after_4", W'(ret), 1);
        chk("ovf_after_4", W'(ovf), 0);
      end
    end
    data_in = 32'h99;
    step();
    chk("ovf_5th", W'(ovf), 1);
    chk("ret_full", W'(ret), 1);
    chk("req_full", W'(req), 1);
    // Push with ack at full: flit dropped, head still popped
    data_in = 32'h77; ack = 1'b1;
    step();
    val = 1'b0;
    chk("ret_after_pop_at_full", W'(ret), W'(EARLY));
    for (int i = 0; i < 3; i++) step();
    ack = 1'b0;
    chk("drain_req", W'(req), 0);
    chk("ovf_sticky", W'(ovf), 1);

    rst_n = 1'b0;
    #1;
    chk("reset2_ovf", W'(ovf), 0);
    step();
    rst_n = 1'b1;
    step();

    // Continuous push and pop, values 1..20
    for (int i = 1; i <= 20; i++) begin
      val = 1'b1; ack = 1'b1; data_in = W'(i); exp_q.push_back(W'(i));
      step();
      chk("stream_ret", W'(ret), 0);
      chk("stream_req", W'(req), 1);
    end
    val = 1'b0;
    step();
    ack = 1'b0;
    chk("stream_end_req", W'(req), 0);

    // Staggered pairs across pointer wrap with two flits resident
    for (int i = 0; i < 2; i++) begin
      val = 1'b1; data_in = 32'h30 + W'(i); exp_q.push_back(32'h30 + W'(i));
      step();
    end
    for (int i = 2; i < 8; i++) begin
      val = 1'b1; ack = 1'b1; data_in = 32'h30 + W'(i); exp_q.push_back(32'h30 + W'(i));
      step();
      chk("wrap_ret", W'(ret), 0);
    end
    val = 1'b0;
    step(); step();
    ack = 1'b0;
    chk("wrap_end_req", W'(req), 0);

    // Reset with three flits stored
    for (int i = 0; i < 3; i++) begin
      val = 1'b1; data_in = 32'h40 + W'(i);
      step();
    end
    val = 1'b0;
    chk("pre_reset_req", W'(req), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", W'(req), 0);
    chk("midrst_ret", W'(ret), 0);
    chk("midrst_ovf", W'(ovf), 0);
    step();
    rst_n = 1'b1;
    step();
    val = 1'b1; data_in = 32'h55; exp_q.push_back(32'h55);
    step();
    val = 1'b0;
    chk("post_reset_head", data_out, 32'h55);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("post_reset_req", W'(req), 0);
    chk("scoreboard_empty", W'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
